inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
Instruction-memory responder for the core's fetch port. It answers the core's chip-enable and word-address requests with 32-bit instruction words. The same storage is filled at boot from a byte-stream loader port using a valid/ready handshake. The block holds the core in reset until a program load completes, and sits beside the core top level on the other end of its ROM interface.

Parameters:
AW, 10, word-address width; depth = 2**AW words (byte addresses 0 .. 4*2**AW-1).
BOOT_RUN, 0, if 1 the block leaves reset in DONE (memory is preloaded by the simulator) and does not hold the core.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
rom_ce_i  in  1  fetch enable from the core.
rom_addr_i  in  32  fetch byte address from the core; word-aligned.
rom_data_o  out  32  instruction word; combinational.
ld_start_i  in  1  single-cycle pulse; begins or restarts a load.
ld_valid_i  in  1  loader byte valid.
ld_byte_i  in  8  loader byte.
ld_last_i  in  1  qualifies the final byte of the image; sampled with ld_valid_i.
ld_ready_o  out  1  block accepts a byte this cycle.
ld_done_o  out  1  image loaded; the core is running.
ld_err_o  out  1  sticky error: overflow or truncated final word.
cpu_rst_o  out  1  reset to the core; high while no valid image is present.

Behaviour:
- Interface: clock port clk; reset port rst, synchronous and active-high. All state updates on the rising edge of clk.
- State machine, encoded in a 2-bit state register:
  - IDLE: ld_ready_o=0, cpu_rst_o=1.
    - ld_start_i -> LOAD.
  - LOAD: ld_ready_o=1, cpu_rst_o=1.
    - ld_start_i restarts the load: wptr=0, bcnt=0, err cleared; no byte accepted that cycle.
    - Accepted byte with ld_last_i=1 -> DONE.
  - DONE: ld_ready_o=0, cpu_rst_o=0, ld_done_o=1.
    - ld_start_i -> LOAD, with cpu_rst_o high from the next cycle.
- Reset values:
  - State = IDLE, or DONE if BOOT_RUN=1.
  - wptr=0, bcnt=0, shift=0, ld_err_o=0.
  - cpu_rst_o=1 and ld_done_o=0 (with BOOT_RUN=1: cpu_rst_o=0, ld_done_o=1).
  - Memory contents are not cleared.
  - Reset mid-load returns to IDLE; partially written words are left as-is.
- Outputs ld_ready_o, ld_done_o and cpu_rst_o decode directly from the state register, with no extra register stage.
- A byte is accepted when ld_valid_i && ld_ready_o && !ld_start_i.
- Byte assembly is big-endian:
  - The first byte of a word goes to [31:24], then [23:16], [15:8], [7:0].
  - bcnt (2 bits) counts bytes within the current word.
- On the 4th accepted byte: mem[wptr] <= {shift[23:0], byte}; wptr++; bcnt wraps to 0. The write occurs on the same edge that accepts the byte.
- Final byte (ld_last_i) with bcnt != 3:
  - Remaining low bytes are padded with 0x00.
  - The padded word is written to mem[wptr].
  - ld_err_o is set; state still goes to DONE.
- Overflow: a word completes when wptr == 2**AW.
  - The word is dropped; ld_err_o is set; wptr saturates.
  - Loading continues until ld_last_i.
- wptr is AW+1 bits wide.
- Fetch read:
  - rom_data_o = mem[rom_addr_i[AW+1:2]] when rom_ce_i=1 and rom_addr_i[31:AW+2]==0; otherwise 32'h0.
  - The read is combinational, so the core latches it in the same cycle (zero wait states).
  - rom_addr_i[1:0] is ignored.
- Read and write to the same address in the same cycle cannot happen, because the core is held in reset during LOAD. This case is unspecified.
- cpu_rst_o falls on the edge after the last byte is accepted. The core's first fetch, at address 0, therefore sees the completed image.

Decomposition:
- Shared defines header: state encodings (LD_IDLE=2'd0, LD_LOAD=2'd1, LD_DONE=2'd2), the ZeroWord constant, and the InstBus/InstAddrBus widths, reused from the core.
- One natural sub-module: inst_mem_ram. It has one synchronous write port and one asynchronous read port, with parameter AW.
- The FSM, byte packer and address decode stay in the top module.

Test Plan:
1. Reset, then start, then bytes 3C,01,12,34,00,00,00,0D with last on the 8th byte.
   - mem[0]=3C011234, mem[1]=0000000D.
   - cpu_rst_o falls one cycle after the last byte; ld_err_o=0.
   - Fetch addr 0x4 with ce=1 returns 0000000D.
2. Fetch with rom_ce_i=0 at addr 0 returns 0. Fetch at addr 4*2**AW (out of range) with ce=1 returns 0.
3. Bytes AA,BB then last CC.
   - mem[0]=AABBCC00, ld_err_o=1, state DONE.
4. With AW=2, stream 5 words (20 bytes), last on the final byte.
   - Words 0..3 are written; the 5th is dropped; ld_err_o=1.
   - mem[0] is unchanged by the overflow.
5. ld_valid_i toggled every other cycle and ld_start_i asserted mid-word.
   - No byte is accepted in the start cycle; bcnt and wptr reset; the next bytes land in mem[0] from [31:24].
6. rst asserted mid-LOAD, one cycle.
   - Next cycle: IDLE, cpu_rst_o=1, ld_ready_o=0, ld_err_o=0.
   - After a fresh start and load, the image is correct. With BOOT_RUN=1, after reset: cpu_rst_o=0, ld_done_o=1.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encodings,
// bus widths borrowed from the core, and the big-endian word packer.
package inst_mem_loader_pkg;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_BUS_W = 32;
   localparam logic [INST_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } ld_state_e;

   // Places the incoming byte after the bytes already gathered; missing low bytes are zero.
   function automatic logic [INST_BUS_W-1:0] pack_word(input logic [23:0] sh,
                                                       input logic [7:0]  b,
                                                       input logic [1:0]  cnt);
      logic [INST_BUS_W-1:0] w;
      case (cnt)
         2'd0:    w = {b, 24'h00_0000};
         2'd1:    w = {sh[7:0], b, 16'h0000};
         2'd2:    w = {sh[15:0], b, 8'h00};
         default: w = {sh[23:0], b};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// Word-wide instruction store: one synchronous write port, one asynchronous read port.
module inst_mem_ram
   import inst_mem_loader_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [INST_BUS_W-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [INST_BUS_W-1:0] rdata_o
);

   logic [INST_BUS_W-1:0] mem_q [2**AW];

   // Write port; contents are deliberately not reset so a preloaded image survives.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory responder for the core fetch port, filled at boot from a
// byte-stream loader; holds the core in reset until an image is complete.
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int AW       = 10,
   parameter int BOOT_RUN = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rom_ce_i,
   input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
   output logic [INST_BUS_W-1:0]      rom_data_o,
   input  logic                       ld_start_i,
   input  logic                       ld_valid_i,
   input  logic [7:0]                 ld_byte_i,
   input  logic                       ld_last_i,
   output logic                       ld_ready_o,
   output logic                       ld_done_o,
   output logic                       ld_err_o,
   output logic                       cpu_rst_o
);

   localparam ld_state_e RST_STATE = (BOOT_RUN != 0) ? LD_DONE : LD_IDLE;
   localparam logic [AW:0] FULL_PTR = {1'b1, {AW{1'b0}}};

   ld_state_e             state_q, state_d;
   logic [AW:0]           wptr_q, wptr_d;
   logic [1:0]            bcnt_q, bcnt_d;
   logic [23:0]           shift_q, shift_d;
   logic                  err_q, err_d;
   logic                  accept_s;
   logic                  word_end_s;
   logic                  we_s;
   logic [INST_BUS_W-1:0] wdata_s;
   logic [INST_BUS_W-1:0] rdata_s;
   logic                  addr_ok_s;
   logic [1:0]            unused_addr_s;

   // Handshake outputs decode straight from the state register.
   always_comb begin
      ld_ready_o = 1'b0;
      ld_done_o  = 1'b0;
      cpu_rst_o  = 1'b1;
      case (state_q)
         LD_IDLE: begin
            ld_ready_o = 1'b0;
            cpu_rst_o  = 1'b1;
         end
         LD_LOAD: begin
            ld_ready_o = 1'b1;
            cpu_rst_o  = 1'b1;
         end
         LD_DONE: begin
            ld_done_o  = 1'b1;
            cpu_rst_o  = 1'b0;
         end
         default: begin
            ld_ready_o = 1'b0;
            cpu_rst_o  = 1'b1;
         end
      endcase
   end

   assign accept_s   = ld_valid_i && ld_ready_o && !ld_start_i;
   assign word_end_s = (bcnt_q == 2'd3) || ld_last_i;

   // Next-state, byte packer and write-pointer logic.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      err_d   = err_q;
      we_s    = 1'b0;
      wdata_s = pack_word(shift_q, ld_byte_i, bcnt_q);
      if (ld_start_i) begin
         state_d = LD_LOAD;
         wptr_d  = '0;
         bcnt_d  = 2'd0;
         shift_d = 24'h00_0000;
         err_d   = 1'b0;
      end else if (accept_s) begin
         shift_d = {shift_q[15:0], ld_byte_i};
         if (word_end_s) begin
            bcnt_d = 2'd0;
            // A full memory drops the word but keeps consuming bytes until the last one.
            if (wptr_q == FULL_PTR) begin
               err_d = 1'b1;
            end else begin
               we_s   = 1'b1;
               wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (ld_last_i) begin
               state_d = LD_DONE;
               err_d   = err_d | (bcnt_q != 2'd3);
            end else begin
               state_d = state_q;
            end
         end else begin
            bcnt_d = bcnt_q + 2'd1;
         end
      end else if (!(state_q inside {LD_IDLE, LD_LOAD, LD_DONE})) begin
         state_d = LD_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         wptr_q  <= '0;
         bcnt_q  <= 2'd0;
         shift_q <= 24'h00_0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         err_q   <= err_d;
      end
   end

   assign ld_err_o = err_q;

   inst_mem_ram #(.AW(AW)) u_ram (
      .clk     (clk),
      .we_i    (we_s),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (wdata_s),
      .raddr_i (rom_addr_i[AW+1:2]),
      .rdata_o (rdata_s)
   );

   // Byte-lane bits of the fetch address carry no information for word fetches.
   assign unused_addr_s = rom_addr_i[1:0];
   assign addr_ok_s     = (rom_addr_i[INST_ADDR_BUS_W-1:AW+2] == '0);
   assign rom_data_o    = (rom_ce_i && addr_ok_s) ? rdata_s : ZERO_WORD;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench: stimulus queues expected fetch data and status flags, a
// monitor compares them on the falling edge of the cycle they were requested in.
module tb_inst_mem_loader;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] data;
      logic [3:0]  flags;   // {cpu_rst, ready, done, err}
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [7:0]  byt = 8'h00;
   logic        last = 1'b0;
   logic        start_v [3];
   logic        valid_v [3];
   logic [31:0] data_w  [3];
   logic        ready_w [3];
   logic        done_w  [3];
   logic        err_w   [3];
   logic        cpurst_w[3];
   logic        check_req = 1'b0;
   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   inst_mem_loader #(.AW(10), .BOOT_RUN(0)) u_dut0 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(data_w[0]),
      .ld_start_i(start_v[0]), .ld_valid_i(valid_v[0]), .ld_byte_i(byt), .ld_last_i(last),
      .ld_ready_o(ready_w[0]), .ld_done_o(done_w[0]), .ld_err_o(err_w[0]), .cpu_rst_o(cpurst_w[0]));

   inst_mem_loader #(.AW(2), .BOOT_RUN(0)) u_dut1 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(data_w[1]),
      .ld_start_i(start_v[1]), .ld_valid_i(valid_v[1]), .ld_byte_i(byt), .ld_last_i(last),
      .ld_ready_o(ready_w[1]), .ld_done_o(done_w[1]), .ld_err_o(err_w[1]), .cpu_rst_o(cpurst_w[1]));

   inst_mem_loader #(.AW(10), .BOOT_RUN(1)) u_dut2 (
      .clk(clk), .rst(rst), .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(data_w[2]),
      .ld_start_i(start_v[2]), .ld_valid_i(valid_v[2]), .ld_byte_i(byt), .ld_last_i(last),
      .ld_ready_o(ready_w[2]), .ld_done_o(done_w[2]), .ld_err_o(err_w[2]), .cpu_rst_o(cpurst_w[2]));

   // Monitor: pops one expectation whenever a check is requested.
   always @(negedge clk) begin
      if (check_req) begin
         exp_t       e;
         logic [3:0] f;
         total = total + 1;
         if (sb_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard-empty: no expectation queued");
         end else begin
            e = sb_q.pop_front();
            f = {cpurst_w[e.sel], ready_w[e.sel], done_w[e.sel], err_w[e.sel]};
            if (data_w[e.sel] !== e.data || f !== e.flags) begin
               bad = bad + 1;
               $display("FAIL %s: got data=%08h flags=%04b, want data=%08h flags=%04b",
                        e.name, data_w[e.sel], f, e.data, e.flags);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         valid_v[i] = 1'b0;
      end
      last      = 1'b0;
      check_req = 1'b0;
   endtask

   task automatic arm_check(input string nm, input int sel, input logic c,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] f);
      exp_t e;
      e.name = nm; e.sel = sel; e.data = d; e.flags = f;
      ce   = c;
      addr = a;
      sb_q.push_back(e);
      check_req = 1'b1;
   endtask

   task automatic do_check(input string nm, input int sel, input logic c,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] f);
      arm_check(nm, sel, c, a, d, f);
      tick();
   endtask

   task automatic pulse_start(input int sel);
      start_v[sel] = 1'b1;
      tick();
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b, input logic l);
      valid_v[sel] = 1'b1;
      byt          = b;
      last         = l;
      tick();
   endtask

   initial begin
      logic [7:0] img1 [8];
      logic [7:0] img6 [8];
      img1 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0D};
      img6 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         valid_v[i] = 1'b0;
      end
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state of all three instances.
      do_check("reset_idle", 0, 1'b0, 32'h0, 32'h0, 4'b1000);
      do_check("reset_idle_aw2", 1, 1'b0, 32'h0, 32'h0, 4'b1000);
      do_check("reset_bootrun", 2, 1'b0, 32'h0, 32'h0, 4'b0010);

      // Test 1: two-word image.
      pulse_start(0);
      do_check("load_state", 0, 1'b0, 32'h0, 32'h0, 4'b1100);
      for (int i = 0; i < 7; i++) send_byte(0, img1[i], 1'b0);
      arm_check("last_byte_cycle", 0, 1'b0, 32'h0, 32'h0, 4'b1100);
      send_byte(0, img1[7], 1'b1);
      do_check("t1_word0", 0, 1'b1, 32'h0, 32'h3C01_1234, 4'b0010);
      do_check("t1_word1", 0, 1'b1, 32'h4, 32'h0000_000D, 4'b0010);
      do_check("t1_lowbits_ignored", 0, 1'b1, 32'h6, 32'h0000_000D, 4'b0010);

      // Test 2: fetch disabled and out of range.
      do_check("t2_ce_low", 0, 1'b0, 32'h0, 32'h0, 4'b0010);
      do_check("t2_out_of_range", 0, 1'b1, 32'h0000_1000, 32'h0, 4'b0010);

      // Test 3: truncated final word.
      arm_check("t3_start_cycle", 0, 1'b0, 32'h0, 32'h0, 4'b0010);
      pulse_start(0);
      do_check("t3_rst_high", 0, 1'b0, 32'h0, 32'h0, 4'b1100);
      send_byte(0, 8'hAA, 1'b0);
      send_byte(0, 8'hBB, 1'b0);
      send_byte(0, 8'hCC, 1'b1);
      do_check("t3_padded", 0, 1'b1, 32'h0, 32'hAABB_CC00, 4'b0011);
      do_check("t3_word1_kept", 0, 1'b1, 32'h4, 32'h0000_000D, 4'b0011);

      // Test 5: gapped valid and restart mid-word.
      pulse_start(0);
      do_check("t5_err_cleared", 0, 1'b0, 32'h0, 32'h0, 4'b1100);
      send_byte(0, 8'h11, 1'b0);
      tick();
      send_byte(0, 8'h22, 1'b0);
      tick();
      start_v[0] = 1'b1;
      send_byte(0, 8'h99, 1'b0);
      send_byte(0, 8'h55, 1'b0);
      tick();
      send_byte(0, 8'h66, 1'b0);
      tick();
      send_byte(0, 8'h77, 1'b0);
      tick();
      send_byte(0, 8'h88, 1'b1);
      do_check("t5_restart_word0", 0, 1'b1, 32'h0, 32'h5566_7788, 4'b0010);
      do_check("t5_word1_kept", 0, 1'b1, 32'h4, 32'h0000_000D, 4'b0010);

      // Test 6: reset mid-load, then a fresh load.
      pulse_start(0);
      for (int i = 1; i <= 5; i++) send_byte(0, 8'(i), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      do_check("t6_after_rst", 0, 1'b0, 32'h0, 32'h0, 4'b1000);
      do_check("t6_bootrun_rst", 2, 1'b0, 32'h0, 32'h0, 4'b0010);
      pulse_start(0);
      for (int i = 0; i < 7; i++) send_byte(0, img6[i], 1'b0);
      send_byte(0, img6[7], 1'b1);
      do_check("t6_word0", 0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'b0010);
      do_check("t6_word1", 0, 1'b1, 32'h4, 32'hCAFE_BABE, 4'b0010);

      // Test 4: overflow on the AW=2 instance (its state was reset above).
      pulse_start(1);
      for (int w = 0; w < 5; w++) begin
         for (int b = 0; b < 4; b++) begin
            if (w == 4 && b == 0)
               arm_check("t4_full_no_err", 1, 1'b0, 32'h0, 32'h0, 4'b1100);
            send_byte(1, {4'(w + 1), 4'(w + 1)}, (w == 4 && b == 3));
         end
      end
      do_check("t4_word0_unchanged", 1, 1'b1, 32'h0, 32'h1111_1111, 4'b0011);
      do_check("t4_word1", 1, 1'b1, 32'h4, 32'h2222_2222, 4'b0011);
      do_check("t4_word2", 1, 1'b1, 32'h8, 32'h3333_3333, 4'b0011);
      do_check("t4_word3", 1, 1'b1, 32'hC, 32'h4444_4444, 4'b0011);
      do_check("t4_out_of_range", 1, 1'b1, 32'h10, 32'h0, 4'b0011);

      tick();
      if (sb_q.size() != 0) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL scoreboard-leftover: got %0d pending, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
